// File: rtl/line_dispatcher_pkg.sv
// Shared definitions for the line dispatcher: FSM encoding and default
// accumulator widths.
package line_dispatcher_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    localparam int DEFAULT_RESULT_WIDTH = 16;
    localparam int DEFAULT_SUM_WIDTH    = 32;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin picker: grants the first requester at or after the priority
// pointer, which moves to one past the winner whenever a grant is consumed.
module rr_arbiter #(
    parameter int WORKER_COUNT = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [WORKER_COUNT-1:0] req_i,
    input  logic                    advance_i,
    output logic [WORKER_COUNT-1:0] grant_o,
    output logic [((WORKER_COUNT > 1) ? $clog2(WORKER_COUNT) : 1)-1:0] grant_idx_o,
    output logic                    any_o
);

    localparam int IDX_W = (WORKER_COUNT > 1) ? $clog2(WORKER_COUNT) : 1;
    localparam logic [IDX_W:0] COUNT_W = (IDX_W + 1)'(WORKER_COUNT);

    logic [IDX_W-1:0] ptr_q;
    logic [IDX_W-1:0] ptr_d;
    logic [IDX_W:0]   cand;
    logic [IDX_W:0]   inc;

    always_comb begin
        grant_o     = '0;
        grant_idx_o = '0;
        any_o       = 1'b0;
        cand        = '0;
        for (int off = 0; off < WORKER_COUNT; off++) begin
            cand = {1'b0, ptr_q} + (IDX_W + 1)'(off);
            if (cand >= COUNT_W) begin
                cand = cand - COUNT_W;
            end
            if (!any_o && req_i[cand[IDX_W-1:0]]) begin
                any_o                       = 1'b1;
                grant_idx_o                 = cand[IDX_W-1:0];
                grant_o[cand[IDX_W-1:0]]    = 1'b1;
            end
        end
    end

    always_comb begin
        inc   = {1'b0, grant_idx_o} + (IDX_W + 1)'(1);
        ptr_d = ptr_q;
        if (advance_i && any_o) begin
            ptr_d = (inc >= COUNT_W) ? '0 : inc[IDX_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/line_dispatcher.sv
// Buffers one puzzle line at a time, hands it to a free solver worker in
// round-robin order and accumulates the workers' minimum-press results.
module line_dispatcher
    import line_dispatcher_pkg::*;
#(
    parameter int MACHINE_COUNT    = 10,
    parameter int MAX_BUTTON_COUNT = 13,
    parameter int BITS_PER_JOLTAGE = 9,
    parameter int WORKER_COUNT     = 4,
    parameter int RESULT_WIDTH     = DEFAULT_RESULT_WIDTH,
    parameter int SUM_WIDTH        = DEFAULT_SUM_WIDTH
) (
    input  logic                                      clk,
    input  logic                                      reset,
    input  logic                                      new_line_given,
    input  logic [$clog2(MAX_BUTTON_COUNT+1)-1:0]     button_count,
    input  logic [MACHINE_COUNT*MAX_BUTTON_COUNT-1:0] flattened_buttons,
    input  logic [MACHINE_COUNT*BITS_PER_JOLTAGE-1:0] flattened_machines,
    input  logic                                      input_done,
    input  logic [WORKER_COUNT-1:0]                   worker_busy,
    input  logic [WORKER_COUNT-1:0]                   worker_result_valid,
    input  logic [WORKER_COUNT*RESULT_WIDTH-1:0]      flattened_results,
    output logic [WORKER_COUNT-1:0]                   worker_start,
    output logic [$clog2(MAX_BUTTON_COUNT+1)-1:0]     job_button_count,
    output logic [MACHINE_COUNT*MAX_BUTTON_COUNT-1:0] job_buttons,
    output logic [MACHINE_COUNT*BITS_PER_JOLTAGE-1:0] job_machines,
    output logic [SUM_WIDTH-1:0]                      total,
    output logic                                      total_valid,
    output logic                                      line_dropped,
    output logic                                      sum_overflow
);

    localparam int BC_W  = $clog2(MAX_BUTTON_COUNT + 1);
    localparam int BTN_W = MACHINE_COUNT * MAX_BUTTON_COUNT;
    localparam int MAC_W = MACHINE_COUNT * BITS_PER_JOLTAGE;
    localparam int OUT_W = $clog2(WORKER_COUNT + 1);
    localparam int IDX_W = (WORKER_COUNT > 1) ? $clog2(WORKER_COUNT) : 1;
    // Wide enough that total plus every worker's maximum result cannot wrap.
    localparam int ACC_W = SUM_WIDTH + RESULT_WIDTH + OUT_W;

    state_e                  state_q, state_d;
    logic                    buf_valid_q, buf_valid_d;
    logic [BC_W-1:0]         buf_count_q, buf_count_d;
    logic [BTN_W-1:0]        buf_buttons_q, buf_buttons_d;
    logic [MAC_W-1:0]        buf_machines_q, buf_machines_d;
    logic [WORKER_COUNT-1:0] worker_start_q, worker_start_d;
    logic [BC_W-1:0]         job_count_q, job_count_d;
    logic [BTN_W-1:0]        job_buttons_q, job_buttons_d;
    logic [MAC_W-1:0]        job_machines_q, job_machines_d;
    logic [SUM_WIDTH-1:0]    total_q, total_d;
    logic                    line_dropped_q, line_dropped_d;
    logic                    sum_overflow_q, sum_overflow_d;
    logic [OUT_W-1:0]        outstanding_q, outstanding_d;

    logic [WORKER_COUNT-1:0] free_mask;
    logic [WORKER_COUNT-1:0] grant;
    logic [IDX_W-1:0]        grant_idx;
    logic                    grant_any;
    logic                    dispatch;
    logic                    active;
    logic [ACC_W-1:0]        masked_result [WORKER_COUNT];
    logic [ACC_W-1:0]        result_sum;
    logic [ACC_W-1:0]        acc_sum;
    logic [OUT_W-1:0]        result_pop;

    // A worker started last edge has not raised busy yet, so it stays reserved.
    assign free_mask = ~worker_busy & ~worker_start_q;
    assign active    = (state_q != ST_DONE);
    assign dispatch  = buf_valid_q && grant_any;

    rr_arbiter #(
        .WORKER_COUNT(WORKER_COUNT)
    ) u_rr_arbiter (
        .clk        (clk),
        .reset      (reset),
        .req_i      (free_mask),
        .advance_i  (dispatch),
        .grant_o    (grant),
        .grant_idx_o(grant_idx),
        .any_o      (grant_any)
    );

    generate
        for (genvar gi = 0; gi < WORKER_COUNT; gi++) begin : g_mask
            assign masked_result[gi] = worker_result_valid[gi]
                ? ACC_W'(flattened_results[gi*RESULT_WIDTH +: RESULT_WIDTH]) : '0;
        end
    endgenerate

    always_comb begin
        result_sum = '0;
        result_pop = '0;
        for (int w = 0; w < WORKER_COUNT; w++) begin
            result_sum = result_sum + masked_result[w];
            result_pop = result_pop + OUT_W'(worker_result_valid[w]);
        end
        acc_sum = ACC_W'(total_q) + result_sum;
    end

    always_comb begin
        state_d        = state_q;
        buf_valid_d    = buf_valid_q;
        buf_count_d    = buf_count_q;
        buf_buttons_d  = buf_buttons_q;
        buf_machines_d = buf_machines_q;
        worker_start_d = '0;
        job_count_d    = job_count_q;
        job_buttons_d  = job_buttons_q;
        job_machines_d = job_machines_q;
        total_d        = total_q;
        line_dropped_d = line_dropped_q;
        sum_overflow_d = sum_overflow_q;
        outstanding_d  = outstanding_q;

        if (dispatch) begin
            worker_start_d = grant;
            job_count_d    = buf_count_q;
            job_buttons_d  = buf_buttons_q;
            job_machines_d = buf_machines_q;
            buf_valid_d    = 1'b0;
        end

        if (new_line_given && active) begin
            if (!buf_valid_q || dispatch) begin
                buf_valid_d    = 1'b1;
                buf_count_d    = button_count;
                buf_buttons_d  = flattened_buttons;
                buf_machines_d = flattened_machines;
            end else begin
                line_dropped_d = 1'b1;
            end
        end

        if (active) begin
            total_d       = acc_sum[SUM_WIDTH-1:0];
            outstanding_d = outstanding_q + OUT_W'(dispatch) - result_pop;
            if (|acc_sum[ACC_W-1:SUM_WIDTH]) begin
                sum_overflow_d = 1'b1;
            end
        end

        case (state_q)
            ST_RUN: begin
                if (input_done) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (!buf_valid_q && outstanding_q == '0 && !(|worker_result_valid)) begin
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_DONE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ST_RUN;
            buf_valid_q    <= 1'b0;
            buf_count_q    <= '0;
            buf_buttons_q  <= '0;
            buf_machines_q <= '0;
            worker_start_q <= '0;
            job_count_q    <= '0;
            job_buttons_q  <= '0;
            job_machines_q <= '0;
            total_q        <= '0;
            line_dropped_q <= 1'b0;
            sum_overflow_q <= 1'b0;
            outstanding_q  <= '0;
        end else begin
            state_q        <= state_d;
            buf_valid_q    <= buf_valid_d;
            buf_count_q    <= buf_count_d;
            buf_buttons_q  <= buf_buttons_d;
            buf_machines_q <= buf_machines_d;
            worker_start_q <= worker_start_d;
            job_count_q    <= job_count_d;
            job_buttons_q  <= job_buttons_d;
            job_machines_q <= job_machines_d;
            total_q        <= total_d;
            line_dropped_q <= line_dropped_d;
            sum_overflow_q <= sum_overflow_d;
            outstanding_q  <= outstanding_d;
        end
    end

    assign worker_start     = worker_start_q;
    assign job_button_count = job_count_q;
    assign job_buttons      = job_buttons_q;
    assign job_machines     = job_machines_q;
    assign total            = total_q;
    assign total_valid      = (state_q == ST_DONE);
    assign line_dropped     = line_dropped_q;
    assign sum_overflow     = sum_overflow_q;

endmodule
